// File: rtl/ddr3_dll_code_ctrl_if.sv
// Code delivery channel between the DLL control block and the delay-line
// consumers: the captured code, its valid flag and the consumer's ack.
interface ddr3_dll_code_ctrl_if;
  logic [7:0] CODE_OUT;
  logic       CODE_VALID;
  logic       CODE_ACK;

  modport master (output CODE_OUT, output CODE_VALID, input CODE_ACK);
  modport slave  (input CODE_OUT, input CODE_VALID, output CODE_ACK);
endinterface

// File: rtl/ddr3_dll_code_ctrl.sv
// DDR3 DLL control: power-up sequencing, lock qualification, periodic and
// drift-triggered code updates, and stable capture of the asynchronous DLL
// code into the SYS_CLK domain with a valid/ack hand-off.
module ddr3_dll_code_ctrl #(
  parameter int unsigned PWRUP_WAIT    = 16,
  parameter int unsigned LOCK_FILTER   = 8,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned UPDATE_PERIOD = 1024,
  parameter int unsigned UPD_PULSE     = 4
) (
  input  logic                        SYS_CLK,
  input  logic                        SYS_RESET_N,
  input  logic                        ENABLE,
  input  logic                        DLL_LOCK,
  input  logic                        DLL_DELAY_DIFF,
  input  logic [7:0]                  DLL_CODE,
  output logic                        DLL_POWERDOWN_N,
  output logic                        DLL_CODE_UPDATE,
  output logic                        READY,
  output logic                        LOCK_LOST,
  output logic                        TIMEOUT_ERR,
  ddr3_dll_code_ctrl_if.master        code_if
);

  localparam int unsigned SETTLE  = 3;
  localparam int unsigned SEQ_MAX = (PWRUP_WAIT > UPD_PULSE + SETTLE) ? PWRUP_WAIT : UPD_PULSE + SETTLE;
  localparam int unsigned SEQ_W   = $clog2(SEQ_MAX + 1);
  localparam int unsigned FLT_W   = $clog2(LOCK_FILTER + 1);
  localparam int unsigned TMO_W   = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned PER_W   = $clog2(UPDATE_PERIOD);

  typedef enum logic [2:0] {
    ST_OFF, ST_PWRUP, ST_WAIT_LOCK, ST_UPDATE, ST_LOCKED, ST_ERROR
  } state_t;

  typedef enum logic [1:0] {
    PH_PULSE, PH_SETTLE, PH_CAPTURE
  } phase_t;

  state_t             r_state;
  phase_t             r_phase;
  logic [SEQ_W-1:0]   r_seq;
  logic [FLT_W-1:0]   r_flt;
  logic [TMO_W-1:0]   r_tmo;
  logic [PER_W-1:0]   r_per;
  logic               r_pend;
  logic [7:0]         r_cap;
  logic               r_cap_vld;

  logic               r_lock_m, r_lock_s;
  logic               r_diff_m, r_diff_s, r_diff_d;
  logic [7:0]         r_code_m, r_code_s;

  logic               r_pd, r_upd, r_code_vld, r_ready, r_lost, r_terr;
  logic [7:0]         r_code_out;

  logic               w_diff_rise;
  logic               w_due;
  logic               w_xfer;

  assign w_diff_rise = r_diff_s & ~r_diff_d;
  assign w_due       = (r_per == PER_W'(UPDATE_PERIOD - 1)) | w_diff_rise;
  assign w_xfer      = r_code_vld & code_if.CODE_ACK;

  assign DLL_POWERDOWN_N    = r_pd;
  assign DLL_CODE_UPDATE    = r_upd;
  assign READY              = r_ready;
  assign LOCK_LOST          = r_lost;
  assign TIMEOUT_ERR        = r_terr;
  assign code_if.CODE_OUT   = r_code_out;
  assign code_if.CODE_VALID = r_code_vld;

  // Two-flop synchronizers for lock/drift, plus double-registered code bus
  always_ff @(posedge SYS_CLK or negedge SYS_RESET_N) begin
    if (!SYS_RESET_N) begin
      r_lock_m <= 1'b0;
      r_lock_s <= 1'b0;
      r_diff_m <= 1'b0;
      r_diff_s <= 1'b0;
      r_diff_d <= 1'b0;
      r_code_m <= '0;
      r_code_s <= '0;
    end else begin
      r_lock_m <= DLL_LOCK;
      r_lock_s <= r_lock_m;
      r_diff_m <= DLL_DELAY_DIFF;
      r_diff_s <= r_diff_m;
      r_diff_d <= r_diff_s;
      r_code_m <= DLL_CODE;
      r_code_s <= r_code_m;
    end
  end

  // Control FSM with registered outputs; ENABLE low overrides every event
  always_ff @(posedge SYS_CLK or negedge SYS_RESET_N) begin
    if (!SYS_RESET_N) begin
      r_state    <= ST_OFF;
      r_phase    <= PH_PULSE;
      r_seq      <= '0;
      r_flt      <= '0;
      r_tmo      <= '0;
      r_per      <= '0;
      r_pend     <= 1'b0;
      r_cap      <= '0;
      r_cap_vld  <= 1'b0;
      r_pd       <= 1'b0;
      r_upd      <= 1'b0;
      r_code_out <= '0;
      r_code_vld <= 1'b0;
      r_ready    <= 1'b0;
      r_lost     <= 1'b0;
      r_terr     <= 1'b0;
    end else if (!ENABLE) begin
      r_state    <= ST_OFF;
      r_phase    <= PH_PULSE;
      r_seq      <= '0;
      r_flt      <= '0;
      r_tmo      <= '0;
      r_per      <= '0;
      r_pend     <= 1'b0;
      r_cap_vld  <= 1'b0;
      r_pd       <= 1'b0;
      r_upd      <= 1'b0;
      r_code_vld <= 1'b0;
      r_ready    <= 1'b0;
      r_lost     <= 1'b0;
      r_terr     <= 1'b0;
    end else begin
      // Consumer handshake; a new capture later in this block overrides it
      if (w_xfer) r_code_vld <= 1'b0;

      case (r_state)
        ST_OFF: begin
          r_pd    <= 1'b1;
          r_seq   <= '0;
          r_state <= ST_PWRUP;
        end

        ST_PWRUP: begin
          if (r_seq == SEQ_W'(PWRUP_WAIT - 1)) begin
            r_seq   <= '0;
            r_flt   <= '0;
            r_tmo   <= '0;
            r_state <= ST_WAIT_LOCK;
          end else begin
            r_seq <= r_seq + 1'b1;
          end
        end

        ST_WAIT_LOCK: begin
          if (r_lock_s && r_flt == FLT_W'(LOCK_FILTER - 1)) begin
            r_state   <= ST_UPDATE;
            r_phase   <= PH_PULSE;
            r_seq     <= '0;
            r_per     <= '0;
            r_pend    <= 1'b0;
            r_cap_vld <= 1'b0;
            r_upd     <= 1'b1;
          end else begin
            r_flt <= r_lock_s ? r_flt + 1'b1 : '0;
            if (r_tmo == TMO_W'(LOCK_TIMEOUT - 1)) begin
              r_terr  <= 1'b1;
              r_state <= ST_ERROR;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
          end
        end

        ST_UPDATE: begin
          if (!r_lock_s) begin
            r_state <= ST_WAIT_LOCK;
            r_flt   <= '0;
            r_tmo   <= '0;
            r_pend  <= 1'b0;
            r_lost  <= 1'b1;
            r_ready <= 1'b0;
            r_upd   <= 1'b0;
          end else begin
            // Period counter runs from pulse start so refresh pulses are evenly spaced
            if (r_per != PER_W'(UPDATE_PERIOD - 1)) r_per <= r_per + 1'b1;
            case (r_phase)
              PH_PULSE: begin
                if (r_seq == SEQ_W'(UPD_PULSE - 1)) begin
                  r_upd   <= 1'b0;
                  r_seq   <= '0;
                  r_phase <= PH_SETTLE;
                end else begin
                  r_seq <= r_seq + 1'b1;
                end
              end
              PH_SETTLE: begin
                if (r_seq == SEQ_W'(SETTLE - 1)) begin
                  r_seq   <= '0;
                  r_phase <= PH_CAPTURE;
                end else begin
                  r_seq <= r_seq + 1'b1;
                end
              end
              PH_CAPTURE: begin
                // Load only on two equal consecutive samples and only into a free slot
                if (r_cap_vld && r_code_s == r_cap && (!r_code_vld || code_if.CODE_ACK)) begin
                  r_code_out <= r_code_s;
                  r_code_vld <= 1'b1;
                  r_ready    <= 1'b1;
                  r_state    <= ST_LOCKED;
                end else begin
                  r_cap     <= r_code_s;
                  r_cap_vld <= 1'b1;
                end
              end
              default: r_phase <= PH_PULSE;
            endcase
          end
        end

        ST_LOCKED: begin
          if (!r_lock_s) begin
            r_state <= ST_WAIT_LOCK;
            r_flt   <= '0;
            r_tmo   <= '0;
            r_pend  <= 1'b0;
            r_lost  <= 1'b1;
            r_ready <= 1'b0;
            r_upd   <= 1'b0;
          end else begin
            r_per <= w_due ? '0 : r_per + 1'b1;
            if (w_due || r_pend) begin
              if (!r_code_vld || code_if.CODE_ACK) begin
                r_state   <= ST_UPDATE;
                r_phase   <= PH_PULSE;
                r_seq     <= '0;
                r_per     <= '0;
                r_pend    <= 1'b0;
                r_cap_vld <= 1'b0;
                r_upd     <= 1'b1;
              end else begin
                r_pend <= 1'b1;
              end
            end
          end
        end

        ST_ERROR: begin
          r_pd    <= 1'b1;
          r_ready <= 1'b0;
          r_upd   <= 1'b0;
        end

        default: r_state <= ST_OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_dll_code_ctrl.sv
// Self-checking bench for ddr3_dll_code_ctrl: randomized scenarios checked
// every cycle against a timestamp/history based reference model, plus
// scenario-level checks derived directly from the parameter values.
module tb_ddr3_dll_code_ctrl;

  localparam int PW  = 4;
  localparam int LF  = 3;
  localparam int LT  = 32;
  localparam int UP  = 64;
  localparam int UPW = 4;
  localparam int MAXC = 4096;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, dll_lock, dll_diff;
  logic [7:0] dll_code;
  logic       pd, upd, ready, lost, terr;

  ddr3_dll_code_ctrl_if code_if ();

  ddr3_dll_code_ctrl #(
    .PWRUP_WAIT(PW), .LOCK_FILTER(LF), .LOCK_TIMEOUT(LT),
    .UPDATE_PERIOD(UP), .UPD_PULSE(UPW)
  ) dut (
    .SYS_CLK(clk), .SYS_RESET_N(rst_n), .ENABLE(en), .DLL_LOCK(dll_lock),
    .DLL_DELAY_DIFF(dll_diff), .DLL_CODE(dll_code), .DLL_POWERDOWN_N(pd),
    .DLL_CODE_UPDATE(upd), .READY(ready), .LOCK_LOST(lost),
    .TIMEOUT_ERR(terr), .code_if(code_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Input history, indexed by the clock edge that sampled the value
  bit       en_h   [0:MAXC-1];
  bit       lock_h [0:MAXC-1];
  bit       diff_h [0:MAXC-1];
  bit       ack_h  [0:MAXC-1];
  bit [7:0] code_h [0:MAXC-1];

  function automatic bit lk(int i);
    return (i >= 1) ? lock_h[i] : 1'b0;
  endfunction
  function automatic bit df(int i);
    return (i >= 1) ? diff_h[i] : 1'b0;
  endfunction
  function automatic bit [7:0] cd(int i);
    return (i >= 1) ? code_h[i] : 8'h00;
  endfunction

  // Reference model: modes with entry timestamps rather than counters
  localparam int M_OFF = 0, M_PWRUP = 1, M_WAIT = 2, M_UPD = 3, M_LOCKED = 4, M_ERR = 5;
  int       m_mode = M_OFF;
  int       t_enter = 0, t0 = 0, per_ref = 0;
  bit       pend = 0;
  bit       m_pd = 0, m_upd = 0, m_vld = 0, m_rdy = 0, m_lost = 0, m_terr = 0;
  bit [7:0] m_out = 8'h00;

  function automatic void start_upd(int c);
    m_mode = M_UPD; t0 = c; per_ref = c; pend = 0; m_upd = 1;
  endfunction

  function automatic void lose(int c);
    m_mode = M_WAIT; t_enter = c; m_lost = 1; m_rdy = 0; m_upd = 0; pend = 0;
  endfunction

  function automatic void model_step(int c);
    bit en_c, ack, ls, dr, got, xfer, loaded, due;
    bit [7:0] cs;
    en_c = en_h[c];
    ack  = ack_h[c];
    ls   = lk(c - 2);
    dr   = df(c - 2) && !df(c - 3);
    cs   = cd(c - 2);
    xfer = m_vld && ack;
    loaded = 0;
    if (!en_c) begin
      m_mode = M_OFF; m_pd = 0; m_upd = 0; m_vld = 0; m_rdy = 0;
      m_lost = 0; m_terr = 0; pend = 0;
      return;
    end
    case (m_mode)
      M_OFF: begin m_mode = M_PWRUP; t_enter = c; m_pd = 1; end
      M_PWRUP: if (c - t_enter == PW) begin m_mode = M_WAIT; t_enter = c; end
      M_WAIT: begin
        got = 1;
        for (int j = 0; j < LF; j++)
          if (c - j <= t_enter || !lk(c - j - 2)) got = 0;
        if (got) start_upd(c);
        else if (c - t_enter == LT) begin m_mode = M_ERR; m_terr = 1; end
      end
      M_UPD: begin
        if (!ls) lose(c);
        else begin
          if (c - t0 >= UPW) m_upd = 0;
          if (c - 1 >= t0 + UPW + 4 && cd(c - 2) == cd(c - 3) && (!m_vld || ack)) begin
            m_out = cs; m_vld = 1; loaded = 1; m_rdy = 1; m_mode = M_LOCKED;
          end
        end
      end
      M_LOCKED: begin
        if (!ls) lose(c);
        else begin
          due = (c - per_ref >= UP) || dr;
          if (due) per_ref = c;
          if (due || pend) begin
            if (!m_vld || ack) start_upd(c);
            else pend = 1;
          end
        end
      end
      default: ;
    endcase
    if (xfer && !loaded) m_vld = 0;
  endfunction

  // Pulse observation on the DUT output
  bit prev_upd = 0;
  int rises = 0, last_rise = 0, prev_rise = 0, hi_cnt = 0, last_width = 0;

  task automatic tick();
    if (cyc + 1 >= MAXC) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", cyc + 1, MAXC);
      $fatal(1);
    end
    cyc++;
    en_h[cyc]   = en;
    lock_h[cyc] = dll_lock;
    diff_h[cyc] = dll_diff;
    ack_h[cyc]  = code_if.CODE_ACK;
    code_h[cyc] = dll_code;
    model_step(cyc);
    @(posedge clk);
    @(negedge clk);
    if (upd && !prev_upd) begin rises++; prev_rise = last_rise; last_rise = cyc; end
    if (upd) hi_cnt++;
    else if (prev_upd) begin last_width = hi_cnt; hi_cnt = 0; end
    prev_upd = upd;
    check("pd",    pd,                 m_pd);
    check("upd",   upd,                m_upd);
    check("code",  code_if.CODE_OUT,   m_out);
    check("valid", code_if.CODE_VALID, m_vld);
    check("ready", ready,              m_rdy);
    check("lost",  lost,               m_lost);
    check("terr",  terr,               m_terr);
  endtask

  task automatic wait_valid(input int budget);
    for (int k = 0; k < budget && !code_if.CODE_VALID; k++) tick();
  endtask

  task automatic wait_rise(input int r0, input int budget);
    for (int k = 0; k < budget && rises == r0; k++) tick();
  endtask

  initial begin
    int r0, e1, ack_cyc;
    bit [7:0] c;
    rst_n = 1'b0; en = 1'b0; dll_lock = 1'b0; dll_diff = 1'b0; dll_code = 8'h00;
    code_if.CODE_ACK = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pd",    pd, 0);
    check("rst_upd",   upd, 0);
    check("rst_code",  code_if.CODE_OUT, 8'h00);
    check("rst_valid", code_if.CODE_VALID, 0);
    check("rst_ready", ready, 0);
    check("rst_lost",  lost, 0);
    check("rst_terr",  terr, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Nominal bring-up
    en = 1'b1;
    repeat (10) tick();
    dll_lock = 1'b1; dll_code = 8'h5A;
    wait_valid(40);
    check("nom_valid", code_if.CODE_VALID, 1);
    check("nom_code",  code_if.CODE_OUT, 8'h5A);
    check("nom_ready", ready, 1);
    check("nom_pulses", rises, 1);
    check("nom_width", last_width, UPW);
    code_if.CODE_ACK = 1'b1;
    tick();
    check("nom_ack_clr", code_if.CODE_VALID, 0);

    // Periodic refresh with immediate ack
    dll_code = 8'h61;
    r0 = rises; wait_rise(r0, 100);
    check("per_spacing", last_rise - prev_rise, UP);
    wait_valid(20);
    check("per_code", code_if.CODE_OUT, 8'h61);
    for (int i = 0; i < 3; i++) begin
      c = 8'($urandom);
      dll_code = c;
      r0 = rises; wait_rise(r0, 100);
      check("per_spacing_rnd", last_rise - prev_rise, UP);
      wait_valid(20);
      check("per_code_rnd", code_if.CODE_OUT, c);
    end

    // Drift-triggered update
    repeat ($urandom_range(2, 20)) tick();
    c = 8'($urandom); dll_code = c;
    r0 = rises;
    dll_diff = 1'b1; repeat (3) tick(); dll_diff = 1'b0;
    wait_rise(r0, 10);
    check("diff_pulse", rises - r0, 1);
    wait_valid(20);
    check("diff_code", code_if.CODE_OUT, c);

    // Deferred update: ack withheld
    code_if.CODE_ACK = 1'b0;
    wait_valid(100);
    check("defer_valid", code_if.CODE_VALID, 1);
    r0 = rises;
    repeat (200) tick();
    check("defer_nopulse", rises - r0, 0);
    code_if.CODE_ACK = 1'b1; ack_cyc = cyc + 1;
    tick();
    code_if.CODE_ACK = 1'b0;
    repeat (30) tick();
    check("defer_one_pulse", rises - r0, 1);
    check("defer_rise_at_ack", last_rise, ack_cyc);
    code_if.CODE_ACK = 1'b1;
    tick();

    // Lock loss, re-lock with a code toggling through the capture window
    repeat ($urandom_range(0, 20)) tick();
    dll_lock = 1'b0;
    repeat (3) tick();
    check("loss_ready", ready, 0);
    check("loss_sticky", lost, 1);
    repeat (4) tick();
    r0 = rises;
    dll_lock = 1'b1;
    for (int k = 0; k < 25; k++) begin
      dll_code = k[0] ? 8'hA5 : 8'h3C;
      tick();
      check("toggle_novalid", code_if.CODE_VALID, 0);
    end
    check("relock_update", rises - r0, 1);
    c = 8'($urandom_range(1, 255)); dll_code = c;
    wait_valid(20);
    check("relock_code", code_if.CODE_OUT, c);

    // Glitchy lock until timeout
    en = 1'b0; dll_lock = 1'b0;
    repeat (2) tick();
    check("off_pd", pd, 0);
    check("off_lost_clr", lost, 0);
    en = 1'b1; e1 = cyc + 1;
    for (int k = 0; k < 80 && !terr; k++) begin
      dll_lock = (k % 3 != 2);
      tick();
    end
    check("tmo_err", terr, 1);
    check("tmo_latency", cyc - e1, PW + LT);
    check("tmo_ready", ready, 0);
    repeat (5) tick();
    check("tmo_err_hold", terr, 1);
    en = 1'b0;
    tick();
    check("tmo_clr", terr, 0);
    check("tmo_pd_off", pd, 0);

    // Asynchronous reset during the update pulse
    dll_lock = 1'b1; en = 1'b1;
    r0 = rises; wait_rise(r0, 60);
    check("mid_upd_high", upd, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pd",    pd, 0);
    check("arst_upd",   upd, 0);
    check("arst_code",  code_if.CODE_OUT, 8'h00);
    check("arst_valid", code_if.CODE_VALID, 0);
    check("arst_ready", ready, 0);
    check("arst_lost",  lost, 0);
    check("arst_terr",  terr, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ddr3_dll_code_ctrl.md
# ddr3_dll_code_ctrl

Control-side companion to the DDR3 DLL wrapper. It sequences DLL power-up, qualifies lock, issues periodic and drift-triggered code-update requests, and captures the multi-bit DLL code safely into the fabric clock domain. It hands each captured code to the delay-line logic through a valid/ack handshake. It sits between the DDR3 DLL instance and the DDR3 PHY delay-line consumers.

## Interface
Parameters:
- PWRUP_WAIT, 16: cycles after power-down release before lock is examined (≥1).
- LOCK_FILTER, 8: consecutive synchronized-lock-high cycles required to declare lock (≥1).
- LOCK_TIMEOUT, 4096: maximum cycles in WAIT_LOCK before error (> LOCK_FILTER).
- UPDATE_PERIOD, 1024: cycles between periodic code updates while locked (≥8).
- UPD_PULSE, 4: width in cycles of DLL_CODE_UPDATE (≥1).

Ports:
- SYS_CLK  in  1  fabric clock; all logic on its rising edge.
- SYS_RESET_N  in  1  asynchronous, active-low reset.
- ENABLE  in  1  level request to run the DLL; low forces OFF.
- DLL_LOCK  in  1  DLL lock, asynchronous to SYS_CLK.
- DLL_DELAY_DIFF  in  1  DLL drift indication, asynchronous.
- DLL_CODE  in  8  DLL delay code, asynchronous, multi-bit.
- DLL_POWERDOWN_N  out  1  to DLL; 0 = powered down.
- DLL_CODE_UPDATE  out  1  to DLL; request code refresh.
- CODE_OUT  out  8  captured code to delay lines.
- CODE_VALID  out  1  CODE_OUT is valid and pending.
- CODE_ACK  in  1  consumer accepts CODE_OUT.
- READY  out  1  DLL locked and at least one code delivered.
- LOCK_LOST  out  1  sticky: lock dropped after LOCKED was reached.
- TIMEOUT_ERR  out  1  sticky: lock not achieved within LOCK_TIMEOUT.

## Operation
- DLL_LOCK and DLL_DELAY_DIFF pass through 2-flop synchronizers (lock_s, diff_s). The control logic sees a 2-cycle input latency.
- DLL_CODE is double-registered. A code is accepted only when two consecutive synchronized samples are equal (stable capture).
- FSM states: OFF, PWRUP, WAIT_LOCK, UPDATE, LOCKED, ERROR.
- OFF: POWERDOWN_N=0, all counters cleared. ENABLE=1 -> PWRUP.
- PWRUP: POWERDOWN_N=1. After PWRUP_WAIT cycles -> WAIT_LOCK. lock_s is ignored in this state.
- WAIT_LOCK: counts consecutive lock_s=1 cycles; a lock_s=0 cycle resets the count. When the count reaches LOCK_FILTER -> UPDATE. If the timeout counter reaches LOCK_TIMEOUT first -> ERROR and TIMEOUT_ERR=1.
- UPDATE sequence:
  - DLL_CODE_UPDATE is driven high for UPD_PULSE cycles.
  - Then 3 settle cycles.
  - Then stable capture: CODE_OUT is loaded and CODE_VALID=1.
  - Then -> LOCKED, READY=1.
- LOCKED: the period counter increments each cycle. An update is due when the counter reaches UPDATE_PERIOD-1, or on a diff_s rising edge; either event clears the counter.
  - Due while CODE_VALID=0 -> UPDATE.
  - Due while CODE_VALID=1 -> held pending until the ack, then UPDATE. At most one pending update is held.
- Lock loss: lock_s=0 in LOCKED or UPDATE -> LOCK_LOST=1, READY=0, DLL_CODE_UPDATE=0, -> WAIT_LOCK with filter and timeout counters cleared. CODE_VALID and CODE_OUT are unchanged.
- ERROR: POWERDOWN_N=1, READY=0; stays until ENABLE=0.
- ENABLE=0 in any state -> OFF on the next edge. This clears CODE_VALID, READY, DLL_CODE_UPDATE, LOCK_LOST and TIMEOUT_ERR. CODE_OUT holds its last value.
- Handshake:
  - A transfer occurs on an edge with CODE_VALID=1 and CODE_ACK=1; CODE_VALID falls on that edge.
  - CODE_OUT is stable while CODE_VALID=1.
  - CODE_ACK while CODE_VALID=0 is ignored.
- Counter widths are sized by $clog2 of each parameter. Counters saturate and never wrap.

## Timing
- Reset values: DLL_POWERDOWN_N=0, DLL_CODE_UPDATE=0, CODE_OUT=8'h00, CODE_VALID=0, READY=0, LOCK_LOST=0, TIMEOUT_ERR=0, FSM=OFF.
- All outputs are registered.
- ENABLE rises at edge N: DLL_POWERDOWN_N=1 after edge N+1.
- Lock declaration: DLL_LOCK rises, then +2 cycles synchronizer, then +LOCK_FILTER cycles -> UPDATE entry.
- UPDATE to CODE_VALID: UPD_PULSE + 3 settle + ≥2 capture cycles; more capture cycles if the code toggles.
- Lock loss: DLL_LOCK falls -> READY=0 after 3 edges.
- Simultaneous update-due and CODE_ACK: ack wins, and UPDATE is entered on the next edge.
- Simultaneous lock loss and update-due: lock loss wins.
- ENABLE=0 has priority over all events.

## Test plan
Bench parameters for all scenarios: PWRUP_WAIT=4, LOCK_FILTER=3, LOCK_TIMEOUT=32, UPDATE_PERIOD=64, UPD_PULSE=4.
- Nominal bring-up: ENABLE=1, DLL_LOCK high 10 cycles later, DLL_CODE=8'h5A -> exactly one 4-cycle DLL_CODE_UPDATE pulse; CODE_OUT=8'h5A with CODE_VALID=1; READY=1; ACK clears VALID.
- Periodic refresh: held locked, ack immediate, DLL_CODE changed to 8'h61 -> next update pulse 64 cycles after the previous one; CODE_OUT=8'h61.
- Deferred update: CODE_ACK withheld for 200 cycles -> no update pulse until the ack; exactly one pulse follows the ack edge.
- Glitchy lock / timeout: DLL_LOCK toggles 1-1-0 repeatedly -> TIMEOUT_ERR=1 after 32 WAIT_LOCK cycles; READY=0; ENABLE=0 clears it and drives POWERDOWN_N=0.
- Lock loss and unstable code:
  - DLL_LOCK dropped in LOCKED -> LOCK_LOST=1, READY=0 within 3 cycles; re-lock restarts UPDATE.
  - DLL_CODE toggled every cycle during capture -> CODE_VALID stays 0 until two equal samples.
- Reset mid-UPDATE: SYS_RESET_N asserted during the update pulse -> all outputs take reset values immediately (asynchronously).
